rgb_led_arbiter: RTL
====================

# rgb_led_arbiter

Shares the single board RGB LED between up to N_REQ status sources (link, error, activity, user) and drives the `rgb` / `blink_en` inputs of the `RgbLed` PWM/blink driver.
- Fixed priority: requester 0 is highest.
- Each grant is held for a minimum display time, so short status pulses stay visible and colours do not flicker between sources.
- All outputs are registered.
- The block sits between the status logic and `RgbLed`, in the same 27 MHz clock domain.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 31'd27_000_000, minimum grant duration in clk cycles (≥1; default 1 s at 27 MHz)
- IDLE_RGB, 24'h000010, idle heartbeat colour (used only with RGB_ARB_HEARTBEAT_EN)

Ports:
- clk  in  1  system clock (27 MHz)
- n_rst  in  1  reset; one clock, reset is synchronous and active-low
- req  in  N_REQ  request per source; level, held while the source wants the LED
- req_rgb  in  24*N_REQ  colour per source, {R,G,B}; source i at bits [24*i+23 : 24*i]
- req_blink  in  N_REQ  blink enable per source
- grant  out  N_REQ  one-hot current owner, or all zero
- rgb  out  24  colour to RgbLed
- blink_en  out  1  blink enable to RgbLed
- busy  out  1  high while any grant is active

## Operation
- States:
  - IDLE: no owner.
  - SHOW: the owner's req is high.
  - LINGER: the owner's req dropped before the minimum hold expired.
- hold_cnt is 31 bits. It clears to 0 in the cycle the new grant first appears, increments each cycle, and saturates at HOLD_CYCLES. hold_done = (hold_cnt == HOLD_CYCLES).
- IDLE:
  - If any req bit is high, grant the lowest-index requester → SHOW.
  - Otherwise output the idle pattern (see Configuration).
- SHOW:
  - rgb and blink_en track the owner's req_rgb / req_blink with one-cycle register delay. Live colour changes by the owner are shown.
  - Owner req low and !hold_done → LINGER.
  - If hold_done and (owner req low, or any higher-priority req high): re-arbitrate among current req bits. Grant the lowest-index active requester → SHOW, or go to IDLE if none.
  - Lower-priority requests never preempt.
- LINGER:
  - rgb and blink_en are frozen at their last values.
  - grant stays on the old owner.
  - The owner re-asserting req → SHOW, without resetting hold_cnt.
  - On hold_done, re-arbitrate as in SHOW.
- Same-cycle events:
  - Owner drop and higher-priority req in the same hold_done cycle: grant the higher requester.
  - Owner drop and another req in the same !hold_done cycle: LINGER.
- Re-arbitrating to the same owner, for example when a higher requester pulsed and dropped, is not a new grant. hold_cnt is not cleared.
- busy = (state != IDLE), registered.
- req_rgb / req_blink of non-owners are ignored.

## Timing
- Reset, applied on any clk edge with n_rst=0, including mid-grant: state=IDLE, grant=0, rgb=24'h000000, blink_en=0, busy=0, hold_cnt=0. The idle pattern appears from the first edge after n_rst=1.
- Grant latency: req rises at edge k. At edge k+1, grant, busy, rgb and blink_en all update together.
- Minimum display: a new grant at edge g cannot be replaced before edge g+HOLD_CYCLES+1. With HOLD_CYCLES=1, switching can occur at edge g+2.
- Tracking latency in SHOW: 1 cycle from req_rgb to rgb.
- Release: owner drops after hold_done at edge k. At edge k+1 the next grant (or IDLE) is visible.

## Configuration
- RGB_ARB_HEARTBEAT_EN defined:
  - In IDLE, rgb=IDLE_RGB and blink_en=1, so RgbLed blinks a dim "alive" pattern.
  - A requester must assert req_blink explicitly to blink.
- Not defined:
  - In IDLE, rgb=24'h000000 and blink_en=0 (LED off).
  - IDLE_RGB is unused.
- No other behaviour differs.

## Test plan
All scenarios use HOLD_CYCLES=8, N_REQ=4, and RgbLed instantiated downstream with BLINK_PERIOD=1000.
- Reset/idle: hold n_rst=0 for 5 cycles, then release.
  - During reset: all outputs 0.
  - Next edge after release, macro off: rgb=0, blink_en=0.
  - Next edge after release, macro on: rgb=24'h000010, blink_en=1.
- Single grant: req[2]=1 with colour 24'h0000FF at edge k.
  - Edge k+1: grant=4'b0100, rgb=24'h0000FF, busy=1.
  - Drop req[2] at k+20 → IDLE at k+21.
- Preemption after hold: req[3] (24'hFFA050) granted at g, req[0] (24'hFF0000) asserted at g+2.
  - grant stays 4'b1000 through edge g+8.
  - grant=4'b0001 and rgb=24'hFF0000 at g+9.
- Linger: req[1] (24'h00FF00) granted at g, dropped at g+2.
  - rgb is frozen at 24'h00FF00 and grant=4'b0010 through g+8.
  - IDLE at g+9.
- Simultaneous requests plus no lower-priority preemption: req[1] and req[3] rise together.
  - req[1] is granted.
  - req[3] stays waiting while req[1] is held for 100 cycles.
  - req[3] is granted 1 cycle after req[1] drops.
- Reset mid-grant: n_rst=0 during SHOW.
  - Next edge: grant=0, busy=0, rgb=0.
  - After release with req still high: regranted one cycle later with hold_cnt restarted.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
// Fixed-priority arbiter sharing one RGB LED between N_REQ status sources, with a minimum grant hold time.
// Optional macro RGB_ARB_HEARTBEAT_EN: blink IDLE_RGB while no source owns the LED.
module rgb_led_arbiter #(
  parameter int          N_REQ       = 4,
  parameter logic [30:0] HOLD_CYCLES = 31'd27_000_000,
  parameter logic [23:0] IDLE_RGB    = 24'h000010
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [24*N_REQ-1:0]   req_rgb,
  input  logic [N_REQ-1:0]      req_blink,
  output logic [N_REQ-1:0]      grant,
  output logic [23:0]           rgb,
  output logic                  blink_en,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    LINGER
  } state_t;

`ifdef RGB_ARB_HEARTBEAT_EN
  localparam logic [23:0] IDLE_PAT   = IDLE_RGB;
  localparam logic        IDLE_BLINK = 1'b1;
`else
  // The heartbeat colour is masked off so the LED stays dark when nothing is requesting.
  localparam logic [23:0] IDLE_PAT   = IDLE_RGB & 24'h000000;
  localparam logic        IDLE_BLINK = 1'b0;
`endif

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_nextState;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   w_nextGrant;
  logic [23:0]        r_rgb;
  logic [23:0]        w_nextRgb;
  logic               r_blink;
  logic               w_nextBlink;
  logic               r_busy;
  logic [30:0]        r_holdCnt;
  logic [30:0]        w_nextHoldCnt;
  logic [30:0]        w_holdInc;
  logic               w_holdDone;
  logic               w_anyReq;
  logic               w_ownerReq;
  logic               w_higherReq;
  logic               w_rearb;
  logic [N_REQ-1:0]   w_lowGrant;
  logic [23:0]        w_lowRgb;
  logic               w_lowBlink;
  logic [23:0]        w_ownerRgb;
  logic               w_ownerBlink;

  assign w_anyReq    = |req;
  assign w_ownerReq  = |(req & r_grant);
  // For a one-hot grant, grant-1 masks exactly the higher-priority (lower-index) sources.
  assign w_higherReq = |(req & (r_grant - ONE));
  assign w_holdDone  = (r_holdCnt == HOLD_CYCLES);
  assign w_holdInc   = w_holdDone ? r_holdCnt : r_holdCnt + 31'd1;

  always_comb begin
    w_lowGrant = '0;
    w_lowRgb   = '0;
    w_lowBlink = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lowGrant    = '0;
        w_lowGrant[i] = 1'b1;
        w_lowRgb      = req_rgb[24*i +: 24];
        w_lowBlink    = req_blink[i];
      end
    end
  end

  always_comb begin
    w_ownerRgb   = '0;
    w_ownerBlink = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_ownerRgb   = req_rgb[24*i +: 24];
        w_ownerBlink = req_blink[i];
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextGrant   = r_grant;
    w_nextRgb     = r_rgb;
    w_nextBlink   = r_blink;
    w_nextHoldCnt = w_holdInc;
    w_rearb       = 1'b0;

    case (r_state)
      IDLE: begin
        w_nextHoldCnt = '0;
        if (w_anyReq) begin
          w_nextState = SHOW;
          w_nextGrant = w_lowGrant;
          w_nextRgb   = w_lowRgb;
          w_nextBlink = w_lowBlink;
        end else begin
          w_nextGrant = '0;
          w_nextRgb   = IDLE_PAT;
          w_nextBlink = IDLE_BLINK;
        end
      end
      SHOW: begin
        if (w_holdDone && (!w_ownerReq || w_higherReq)) begin
          w_rearb = 1'b1;
        end else if (!w_ownerReq) begin
          w_nextState = LINGER;
        end else begin
          w_nextRgb   = w_ownerRgb;
          w_nextBlink = w_ownerBlink;
        end
      end
      LINGER: begin
        if (w_holdDone) begin
          w_rearb = 1'b1;
        end else if (w_ownerReq) begin
          w_nextState = SHOW;
          w_nextRgb   = w_ownerRgb;
          w_nextBlink = w_ownerBlink;
        end
      end
      default: begin
        w_nextState   = IDLE;
        w_nextGrant   = '0;
        w_nextRgb     = '0;
        w_nextBlink   = 1'b0;
        w_nextHoldCnt = '0;
      end
    endcase

    // Winning back the same owner keeps the running hold count.
    if (w_rearb) begin
      if (w_anyReq) begin
        w_nextState = SHOW;
        w_nextGrant = w_lowGrant;
        w_nextRgb   = w_lowRgb;
        w_nextBlink = w_lowBlink;
        if (w_lowGrant != r_grant) begin
          w_nextHoldCnt = '0;
        end
      end else begin
        w_nextState   = IDLE;
        w_nextGrant   = '0;
        w_nextRgb     = IDLE_PAT;
        w_nextBlink   = IDLE_BLINK;
        w_nextHoldCnt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rgb     <= '0;
      r_blink   <= 1'b0;
      r_busy    <= 1'b0;
      r_holdCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_grant   <= w_nextGrant;
      r_rgb     <= w_nextRgb;
      r_blink   <= w_nextBlink;
      r_busy    <= (w_nextState != IDLE);
      r_holdCnt <= w_nextHoldCnt;
    end
  end

  assign grant    = r_grant;
  assign rgb      = r_rgb;
  assign blink_en = r_blink;
  assign busy     = r_busy;

endmodule
